fft_mag_framer: RTL

- Producer end of the FFT magnitude stream: accepts complex FFT output bins and computes squared magnitude re²+im².
- Buffers one full frame of magnitudes, then replays it as an unbroken burst on mag/mag_valid.
- The burst is exactly NSamples consecutive valid cycles, which is what the downstream peak finder requires; it resets its bin index whenever valid drops.
- Sits between the streaming FFT core and the peak finder. Bin order is preserved as produced by the FFT (bit-reversed); no reordering is done here.

---
 rtl/fft_stream_pkg.sv | 16 +
 rtl/frame_ram.sv | 35 +++
 rtl/fft_mag_framer.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/fft_stream_pkg.sv
// rtl/fft_stream_pkg.sv - shared defaults and state encoding for the FFT magnitude stream
package fft_stream_pkg;

    localparam int NSamplesDef = 1024;
    localparam int DWDef       = 16;
    localparam int WDef        = 2 * DWDef + 1;
    localparam int NBitsDef    = $clog2(NSamplesDef);

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        FLUSH,
        DRAIN
    } state_t;

endpackage

// File: rtl/frame_ram.sv
// rtl/frame_ram.sv - simple dual-port frame buffer, one write port, one registered read port
module frame_ram #(
    parameter int Depth = 1024,
    parameter int Width = 33,
    parameter int AW    = $clog2(Depth)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [Width-1:0] wr_data,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [Width-1:0] rd_data
);

    logic [Width-1:0] mem [Depth];

    // Write port: the array itself carries no reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Read port: output register holds its value between reads and clears on reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/fft_mag_framer.sv
// rtl/fft_mag_framer.sv - squares FFT bins, buffers one frame, replays it as an unbroken burst
module fft_mag_framer
    import fft_stream_pkg::*;
#(
    parameter int NSamples = NSamplesDef,
    parameter int DW       = DWDef,
    parameter int W        = 2 * DW + 1,
    parameter int NBits    = $clog2(NSamples)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic signed [DW-1:0] fft_re,
    input  logic signed [DW-1:0] fft_im,
    input  logic                 fft_valid,
    input  logic                 fft_sop,
    input  logic                 fft_eop,
    output logic                 fft_ready,
    output logic [W-1:0]         mag,
    output logic                 mag_valid,
    output logic                 frame_err
);

    localparam logic [NBits-1:0] LastIdx = NBits'(NSamples - 1);

    state_t             state, state_nx;
    logic [NBits-1:0]   wr_idx, wr_idx_nx;
    logic [NBits-1:0]   rd_idx, rd_idx_nx;
    logic               flush_cnt, flush_cnt_nx;
    logic               accept;
    logic               wr_req;
    logic [NBits-1:0]   wr_addr_c;
    logic               err_c;
    logic               rd_en;
    logic               ready_nx;

    // Multiply-add pipeline registers.
    logic signed [2*DW-1:0] re_x, im_x;
    logic signed [2*DW-1:0] p_re, p_im;
    logic                   s1_valid, s2_valid;
    logic [NBits-1:0]       s1_addr, s2_addr;
    logic [W-1:0]           s2_sum;

    assign accept = fft_valid && fft_ready;
    assign re_x   = (2*DW)'(fft_re);
    assign im_x   = (2*DW)'(fft_im);

    // Next-state, write-address and error decode; sop always forces address 0.
    always_comb begin
        state_nx     = state;
        wr_idx_nx    = wr_idx;
        rd_idx_nx    = rd_idx;
        flush_cnt_nx = flush_cnt;
        wr_req       = 1'b0;
        wr_addr_c    = fft_sop ? '0 : wr_idx;
        err_c        = 1'b0;
        rd_en        = 1'b0;
        case (state)
            IDLE: begin
                if (accept && fft_sop) begin
                    wr_req = 1'b1;
                    if (fft_eop) begin
                        err_c     = 1'b1;
                        wr_idx_nx = '0;
                    end else begin
                        wr_idx_nx = NBits'(1);
                        state_nx  = FILL;
                    end
                end
            end
            FILL: begin
                if (accept) begin
                    wr_req = 1'b1;
                    if (fft_sop) begin
                        err_c = 1'b1;
                        if (fft_eop) begin
                            state_nx  = IDLE;
                            wr_idx_nx = '0;
                        end else begin
                            wr_idx_nx = NBits'(1);
                        end
                    end else if (fft_eop) begin
                        wr_idx_nx = '0;
                        if (wr_idx == LastIdx) begin
                            state_nx     = FLUSH;
                            flush_cnt_nx = 1'b0;
                        end else begin
                            err_c    = 1'b1;
                            state_nx = IDLE;
                        end
                    end else if (wr_idx == LastIdx) begin
                        err_c     = 1'b1;
                        state_nx  = IDLE;
                        wr_idx_nx = '0;
                    end else begin
                        wr_idx_nx = wr_idx + NBits'(1);
                    end
                end
            end
            FLUSH: begin
                flush_cnt_nx = 1'b1;
                if (flush_cnt) begin
                    state_nx     = DRAIN;
                    rd_idx_nx    = '0;
                    flush_cnt_nx = 1'b0;
                end
            end
            DRAIN: begin
                rd_en     = 1'b1;
                rd_idx_nx = rd_idx + NBits'(1);
                if (rd_idx == LastIdx) begin
                    state_nx  = IDLE;
                    rd_idx_nx = '0;
                end
            end
            default: state_nx = IDLE;
        endcase
        // Ready stays low through the whole burst and returns once DRAIN has been left.
        ready_nx = (state_nx == IDLE || state_nx == FILL) && (state != DRAIN);
    end

    // Control state, registered handshake and status outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            wr_idx    <= '0;
            rd_idx    <= '0;
            flush_cnt <= 1'b0;
            fft_ready <= 1'b0;
            frame_err <= 1'b0;
            mag_valid <= 1'b0;
        end else begin
            state     <= state_nx;
            wr_idx    <= wr_idx_nx;
            rd_idx    <= rd_idx_nx;
            flush_cnt <= flush_cnt_nx;
            fft_ready <= ready_nx;
            frame_err <= err_c;
            mag_valid <= (state == DRAIN);
        end
    end

    // Stage 1 squares each component; stage 2 adds them into the unsigned magnitude.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_addr  <= '0;
            p_re     <= '0;
            p_im     <= '0;
            s2_valid <= 1'b0;
            s2_addr  <= '0;
            s2_sum   <= '0;
        end else begin
            s1_valid <= wr_req;
            s1_addr  <= wr_addr_c;
            p_re     <= re_x * re_x;
            p_im     <= im_x * im_x;
            s2_valid <= s1_valid;
            s2_addr  <= s1_addr;
            s2_sum   <= W'($unsigned(p_re)) + W'($unsigned(p_im));
        end
    end

    frame_ram #(
        .Depth (NSamples),
        .Width (W),
        .AW    (NBits)
    ) u_frame_ram (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (s2_valid),
        .wr_addr (s2_addr),
        .wr_data (s2_sum),
        .rd_en   (rd_en),
        .rd_addr (rd_idx),
        .rd_data (mag)
    );

endmodule
